// File: rtl/z80_bus_sequencer.sv
// Z80 T-state bus-cycle generator: fetch, mem rd/wr, io rd/wr and INTA with wait states and nWAIT.
// Define Z80_BUS_REFRESH_EN to run DRAM refresh (R counter, nRFSH) during fetch T3/T4.
module z80_bus_sequencer #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 8,
   parameter int M1_WAIT  = 0,
   parameter int MEM_WAIT = 0,
   parameter int IO_WAIT  = 1
) (
   input  logic              CLK,
   input  logic              nRESET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_type,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ADDRESS,
   output logic [DATA_W-1:0] DATA_OUT,
   output logic              DATA_OE,
   input  logic [DATA_W-1:0] DATA_IN,
   output logic              nMREQ,
   output logic              nIORQ,
   output logic              nRD,
   output logic              nWR,
   output logic              nM1,
   output logic              nRFSH,
   input  logic              nWAIT,
   input  logic [7:0]        refresh_i
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_T1 = 3'd1, ST_T2 = 3'd2, ST_TW = 3'd3, ST_T3 = 3'd4, ST_T4 = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CY_FETCH = 3'd0, CY_MEMRD = 3'd1, CY_MEMWR = 3'd2,
      CY_IORD  = 3'd3, CY_IOWR  = 3'd4, CY_INTA  = 3'd5
   } cycle_t;

   function automatic cycle_t decode_type(input logic [2:0] t);
      case (t)
         3'd0:    return CY_FETCH;
         3'd1:    return CY_MEMRD;
         3'd2:    return CY_MEMWR;
         3'd3:    return CY_IORD;
         3'd4:    return CY_IOWR;
         3'd5:    return CY_INTA;
         default: return CY_MEMRD;
      endcase
   endfunction

   function automatic logic [7:0] wait_states(input cycle_t c);
      case (c)
         CY_FETCH:          return 8'(M1_WAIT);
         CY_MEMRD, CY_MEMWR: return 8'(MEM_WAIT);
         CY_IORD, CY_IOWR:   return 8'(IO_WAIT);
         CY_INTA:           return 8'd2;
         default:           return 8'd0;
      endcase
   endfunction

   function automatic logic is_read(input cycle_t c);
      case (c)
         CY_FETCH, CY_MEMRD, CY_IORD, CY_INTA: return 1'b1;
         default:                              return 1'b0;
      endcase
   endfunction

   state_t              state_q, state_d;
   cycle_t              cyc_q, cyc_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [7:0]          wcnt_q, wcnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [ADDR_W-1:0]   address_q, address_d;
   logic                n_m1_q, n_mreq_q, n_iorq_q, n_rd_q, n_wr_q, n_rfsh_q;
   logic                n_m1_d, n_mreq_d, n_iorq_d, n_rd_d, n_wr_d, n_rfsh_d;
   logic                oe_q, oe_d, done_q, done_d, ready_q, ready_d;
   logic [7:0]          r_q, r_d;

`ifdef Z80_BUS_REFRESH_EN
   logic [15:0]         rfsh_addr_s;
   assign rfsh_addr_s = {refresh_i, r_q};
`else
   logic                unused_refresh_s;
   assign unused_refresh_s = ^refresh_i;
`endif

   // Cycle sequencing: state, wait counter, captured request, read data and R counter.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wcnt_d  = wcnt_q;
      rdata_d = rdata_q;
      r_d     = r_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_T1;
               cyc_d   = decode_type(req_type);
               addr_d  = req_addr;
               wdata_d = req_wdata;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_T1: begin
            state_d = ST_T2;
            wcnt_d  = wait_states(cyc_q);
         end
         ST_T2, ST_TW: begin
            if ((wcnt_q != 8'd0) || !nWAIT) begin
               state_d = ST_TW;
               if (wcnt_q != 8'd0) begin
                  wcnt_d = wcnt_q - 8'd1;
               end else begin
                  wcnt_d = wcnt_q;
               end
            end else begin
               state_d = ST_T3;
               if (is_read(cyc_q)) begin
                  rdata_d = DATA_IN;
               end else begin
                  rdata_d = rdata_q;
               end
            end
         end
         ST_T3: begin
            if (cyc_q == CY_FETCH) begin
               state_d = ST_T4;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_T4: begin
            state_d = ST_IDLE;
`ifdef Z80_BUS_REFRESH_EN
            r_d = {r_q[7], r_q[6:0] + 7'd1};
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus strobe and address values for the state being entered.
   always_comb begin
      n_m1_d   = 1'b1;
      n_mreq_d = 1'b1;
      n_iorq_d = 1'b1;
      n_rd_d   = 1'b1;
      n_wr_d   = 1'b1;
      n_rfsh_d = 1'b1;
      oe_d     = 1'b0;
      done_d   = (state_d == ST_T3);
      ready_d  = (state_d == ST_IDLE);
      if (state_d != ST_IDLE) begin
         address_d = addr_d;
      end else begin
         address_d = address_q;
      end
      case (cyc_d)
         CY_FETCH: begin
            case (state_d)
               ST_T1, ST_T2, ST_TW: begin
                  n_m1_d   = 1'b0;
                  n_mreq_d = 1'b0;
                  n_rd_d   = 1'b0;
               end
`ifdef Z80_BUS_REFRESH_EN
               ST_T3: begin
                  n_rfsh_d  = 1'b0;
                  address_d = ADDR_W'(rfsh_addr_s);
               end
               ST_T4: begin
                  n_rfsh_d  = 1'b0;
                  n_mreq_d  = 1'b0;
                  address_d = ADDR_W'(rfsh_addr_s);
               end
`endif
               default: ;
            endcase
         end
         CY_MEMRD, CY_MEMWR: begin
            if (state_d != ST_IDLE) begin
               n_mreq_d = 1'b0;
               if (cyc_d == CY_MEMRD) begin
                  n_rd_d = 1'b0;
               end else begin
                  oe_d   = 1'b1;
                  n_wr_d = (state_d == ST_T1);
               end
            end else begin
               n_mreq_d = 1'b1;
            end
         end
         CY_IORD, CY_IOWR: begin
            if ((state_d != ST_IDLE) && (state_d != ST_T1)) begin
               n_iorq_d = 1'b0;
               if (cyc_d == CY_IORD) begin
                  n_rd_d = 1'b0;
               end else begin
                  n_wr_d = 1'b0;
               end
            end else begin
               n_iorq_d = 1'b1;
            end
            oe_d = (cyc_d == CY_IOWR) && (state_d != ST_IDLE);
         end
         CY_INTA: begin
            n_m1_d   = (state_d == ST_IDLE);
            n_iorq_d = !((state_d == ST_TW) || (state_d == ST_T3));
         end
         default: ;
      endcase
   end

   // State and registered bus outputs; nRESET low aborts any cycle on this edge.
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state_q   <= ST_IDLE;
         cyc_q     <= CY_FETCH;
         addr_q    <= '0;
         wdata_q   <= '0;
         wcnt_q    <= 8'd0;
         rdata_q   <= '0;
         address_q <= '0;
         n_m1_q    <= 1'b1;
         n_mreq_q  <= 1'b1;
         n_iorq_q  <= 1'b1;
         n_rd_q    <= 1'b1;
         n_wr_q    <= 1'b1;
         n_rfsh_q  <= 1'b1;
         oe_q      <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
         r_q       <= 8'd0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wcnt_q    <= wcnt_d;
         rdata_q   <= rdata_d;
         address_q <= address_d;
         n_m1_q    <= n_m1_d;
         n_mreq_q  <= n_mreq_d;
         n_iorq_q  <= n_iorq_d;
         n_rd_q    <= n_rd_d;
         n_wr_q    <= n_wr_d;
         n_rfsh_q  <= n_rfsh_d;
         oe_q      <= oe_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
         r_q       <= r_d;
      end
   end

   assign req_ready = ready_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign ADDRESS   = address_q;
   assign DATA_OUT  = wdata_q;
   assign DATA_OE   = oe_q;
   assign nMREQ     = n_mreq_q;
   assign nIORQ     = n_iorq_q;
   assign nRD       = n_rd_q;
   assign nWR       = n_wr_q;
   assign nM1       = n_m1_q;
   assign nRFSH     = n_rfsh_q;

endmodule

// File: tb/tb_z80_bus_sequencer.sv
// Scoreboard bench for z80_bus_sequencer: per-clock bus trace and rdata checked against a T-state model.
module tb_z80_bus_sequencer;
   localparam int ADDR_W   = 16;
   localparam int DATA_W   = 8;
   localparam int M1_WAIT  = 0;
   localparam int MEM_WAIT = 0;
   localparam int IO_WAIT  = 1;
`ifdef Z80_BUS_REFRESH_EN
   localparam bit RFSH = 1'b1;
`else
   localparam bit RFSH = 1'b0;
`endif

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic              nRESET, req_valid, req_ready, done, DATA_OE, nWAIT;
   logic [2:0]        req_type;
   logic [15:0]       req_addr, ADDRESS;
   logic [7:0]        req_wdata, rdata, DATA_OUT, DATA_IN, refresh_i;
   logic              nMREQ, nIORQ, nRD, nWR, nM1, nRFSH;

   z80_bus_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .M1_WAIT(M1_WAIT), .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT)
   ) dut (
      .CLK(CLK), .nRESET(nRESET), .req_valid(req_valid), .req_ready(req_ready),
      .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
      .rdata(rdata), .ADDRESS(ADDRESS), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
      .DATA_IN(DATA_IN), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
      .nM1(nM1), .nRFSH(nRFSH), .nWAIT(nWAIT), .refresh_i(refresh_i)
   );

   // strb bits: {nM1,nMREQ,nIORQ,nRD,nWR,nRFSH}
   typedef struct packed {
      logic [5:0]  strb;
      logic        oe;
      logic        done;
      logic        ready;
      logic [15:0] addr;
      logic [7:0]  dout;
   } bus_t;

   bus_t        exp_q[$];
   logic [7:0]  rd_q[$];
   bus_t        idle_exp;
   int          tests = 0;
   int          fails = 0;
   bit          mon_en = 1'b0;
   logic [15:0] last_addr;
   logic [7:0]  last_wdata, last_rdata, r_cnt;

   // phase: 1=T1 2=T2 3=TW 4=T3 5=T4
   function automatic logic [5:0] strobes(input int t, input int ph);
      case (t)
         0: begin
            if (ph <= 3) return 6'b001011;
            else if (!RFSH) return 6'b111111;
            else if (ph == 4) return 6'b111110;
            else return 6'b101110;
         end
         1: return 6'b101011;
         2: return (ph == 1) ? 6'b101111 : 6'b101101;
         3: return (ph == 1) ? 6'b111111 : 6'b110011;
         4: return (ph == 1) ? 6'b111111 : 6'b110101;
         5: return (ph <= 2) ? 6'b011111 : 6'b010111;
         default: return 6'b111111;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      last_addr  = 16'h0000;
      last_wdata = 8'h00;
      last_rdata = 8'h00;
      r_cnt      = 8'h00;
      idle_exp   = {6'b111111, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00};
   endtask

   task automatic wait_ready();
      int guard;
      guard = 0;
      @(negedge CLK);
      while (!req_ready && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
   endtask

   // lw = number of leading nWAIT samples (T2, then TWs) held low
   task automatic issue(input int t, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] din, input int lw, input logic [7:0] ri);
      int te, w, ntw, reps;
      bit rd;
      bus_t v;
      logic [15:0] ra;
      wait_ready();
      tests++;
      if (!req_ready) begin
         fails++;
         $display("FAIL ready_wait actual=0 required=1");
         return;
      end
      te  = (t > 5) ? 1 : t;
      w   = (te == 0) ? M1_WAIT : (te <= 2) ? MEM_WAIT : (te <= 4) ? IO_WAIT : 2;
      ntw = (w > lw) ? w : lw;
      ra  = {ri, r_cnt};
      rd  = (te == 0) || (te == 1) || (te == 3) || (te == 5);
      for (int ph = 1; ph <= 5; ph++) begin
         reps = (ph == 3) ? ntw : ((ph == 5 && te != 0) ? 0 : 1);
         for (int k = 0; k < reps; k++) begin
            v.strb  = strobes(te, ph);
            v.oe    = (te == 2) || (te == 4);
            v.done  = (ph == 4);
            v.ready = 1'b0;
            v.addr  = (te == 0 && ph >= 4 && RFSH) ? ra : a;
            v.dout  = wd;
            exp_q.push_back(v);
         end
      end
      last_addr  = (te == 0 && RFSH) ? ra : a;
      last_wdata = wd;
      if (rd) last_rdata = din;
      rd_q.push_back(last_rdata);
      if (te == 0 && RFSH) r_cnt = {r_cnt[7], r_cnt[6:0] + 7'd1};
      idle_exp = {6'b111111, 1'b0, 1'b0, 1'b1, last_addr, last_wdata};

      req_valid = 1'b1;
      req_type  = 3'(t);
      req_addr  = a;
      req_wdata = wd;
      DATA_IN   = din;
      refresh_i = ri;
      nWAIT     = 1'b1;
      @(negedge CLK);
      req_valid = 1'b0;
      req_addr  = 16'($urandom);
      req_wdata = 8'($urandom);
      req_type  = 3'($urandom);
      for (int i = 0; i <= lw; i++) begin
         @(negedge CLK);
         nWAIT = (i < lw) ? 1'b0 : 1'b1;
      end
   endtask

   // Monitor: one expected bus vector per clock, idle vector when no cycle is pending.
   initial begin
      bus_t act, exp;
      forever begin
         @(posedge CLK);
         #1;
         if (mon_en) begin
            act = {nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, DATA_OE, done, req_ready, ADDRESS, DATA_OUT};
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else exp = idle_exp;
            chk("bus_vector", 64'(act), 64'(exp));
            if (done) begin
               if (rd_q.size() > 0) begin
                  chk("rdata", 64'(rdata), 64'(rd_q.pop_front()));
               end else begin
                  chk("unexpected_done", 64'(done), 64'(1'b0));
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, lw, guard;
      nRESET = 1'b0; req_valid = 1'b0; req_type = 3'd0; req_addr = 16'h0;
      req_wdata = 8'h0; DATA_IN = 8'h0; nWAIT = 1'b1; refresh_i = 8'h0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_strobes", 64'({nM1, nMREQ, nIORQ, nRD, nWR, nRFSH}), 64'(6'b111111));
      chk("reset_ready_oe_done", 64'({req_ready, DATA_OE, done}), 64'(3'b100));
      chk("reset_addr_data", 64'({ADDRESS, DATA_OUT, rdata}), 64'(32'h0));
      @(negedge CLK);
      nRESET = 1'b1;
      mon_en = 1'b1;

      issue(1, 16'h1234, 8'h00, 8'hA5, 0, 8'h00);
      issue(4, 16'h00FE, 8'h3C, 8'h5A, 3, 8'h00);
      issue(5, 16'h0038, 8'h00, 8'hFF, 0, 8'h00);
      issue(2, 16'hFFFF, 8'hC3, 8'h11, 2, 8'h00);
      issue(6, 16'h8000, 8'h00, 8'h66, 0, 8'h00);
      issue(7, 16'h4001, 8'h00, 8'h99, 1, 8'h00);
`ifdef Z80_BUS_REFRESH_EN
      for (int n = 0; n < 121; n++) begin
         issue(0, 16'($urandom), 8'($urandom), 8'($urandom), 0, 8'($urandom));
      end
      for (int n = 0; n < 6; n++) begin
         issue(0, 16'($urandom), 8'($urandom), 8'($urandom), 0, 8'($urandom));
      end
      issue(0, 16'h0000, 8'h00, 8'h3E, 0, 8'h80);
`endif
      for (int n = 0; n < 200; n++) begin
         t  = $urandom_range(0, 7);
         lw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         issue(t, 16'($urandom), 8'($urandom), 8'($urandom), lw, 8'($urandom));
      end

      // abort a memory write in TW with nRESET
      wait_ready();
      mon_en    = 1'b0;
      req_valid = 1'b1; req_type = 3'd2; req_addr = 16'hBEEF; req_wdata = 8'h77; nWAIT = 1'b1;
      @(negedge CLK);
      req_valid = 1'b0;
      @(negedge CLK);
      nWAIT = 1'b0;
      @(negedge CLK);
      chk("memwr_in_tw", 64'({nMREQ, nWR, DATA_OE, done}), 64'(4'b0010));
      nRESET = 1'b0;
      @(posedge CLK);
      #1;
      chk("abort_strobes", 64'({nM1, nMREQ, nIORQ, nRD, nWR, nRFSH}), 64'(6'b111111));
      chk("abort_ready_oe_done", 64'({req_ready, DATA_OE, done}), 64'(3'b100));
      chk("abort_addr_data", 64'({ADDRESS, DATA_OUT, rdata}), 64'(32'h0));
      @(negedge CLK);
      nRESET = 1'b1;
      nWAIT  = 1'b1;
      model_reset();
      mon_en = 1'b1;

      for (int n = 0; n < 20; n++) begin
         t  = $urandom_range(0, 7);
         lw = $urandom_range(0, 2);
         issue(t, 16'($urandom), 8'($urandom), 8'($urandom), lw, 8'($urandom));
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 200) begin
         @(negedge CLK);
         guard++;
      end
      chk("drain_pending", 64'(exp_q.size()), 64'(0));
      repeat (3) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
